// File: rtl/uart_tx_sched_if.sv
// Requester-side handshake bus for uart_tx_sched: producers offer bytes, the scheduler pulses ready.
interface uart_tx_sched_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;

    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among N_REQ requesters, with per-requester
// frame configuration and a watchdog that resets a hung transmitter.
module uart_tx_sched #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             tx_clk,
    input  logic             rst,
    uart_tx_sched_if.slave   req_bus,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_sel,
    input  logic [3:0]       cfg_length,
    input  logic             cfg_parity_en,
    input  logic             cfg_parity_type,
    input  logic             cfg_stop2,
    output logic             cfg_err,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic [3:0]       length,
    output logic             parity_type,
    output logic             parity_en,
    output logic             stop2,
    output logic             uart_rst,
    input  logic             tx_done,
    output logic             busy,
    output logic             done_valid,
    output logic             err_valid,
    output logic [2:0]       owner_id
);
    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, ABORT} state_t;

    state_t            state;
    state_t            state_next;
    logic [TW-1:0]     timer;
    logic [2:0]        ptr;
    logic [2:0]        next_ptr;
    logic [2:0]        grant;
    logic              any_valid;
    logic              cfg_bad;
    logic              timeout_hit;
    logic [N_REQ-1:0]  ready_vec;

    logic [3:0]        cfg_length_q [N_REQ];
    logic [N_REQ-1:0]  cfg_parity_en_q;
    logic [N_REQ-1:0]  cfg_parity_type_q;
    logic [N_REQ-1:0]  cfg_stop2_q;

    // Round robin: lowest valid index at or above ptr, else wrap to the lowest valid index.
    always_comb begin
        logic [2:0] hi_grant;
        logic [2:0] lo_grant;
        logic       hi_any;
        hi_grant  = '0;
        lo_grant  = '0;
        hi_any    = 1'b0;
        any_valid = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_bus.req_valid[i]) begin
                lo_grant  = 3'(i);
                any_valid = 1'b1;
                if (3'(i) >= ptr) begin
                    hi_grant = 3'(i);
                    hi_any   = 1'b1;
                end
            end
        end
        grant = hi_any ? hi_grant : lo_grant;
    end

    assign next_ptr    = (owner_id == 3'(N_REQ - 1)) ? 3'd0 : owner_id + 3'd1;
    assign timeout_hit = (timer == TW'(TIMEOUT_CYC - 1));
    assign cfg_bad     = cfg_we && ((cfg_length < 4'd5) || (cfg_length > 4'd8) ||
                                    ({29'd0, cfg_sel} >= 32'(N_REQ)));

    always_ff @(posedge tx_clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                cfg_length_q[i] <= 4'd8;
            end
            cfg_parity_en_q   <= '0;
            cfg_parity_type_q <= '0;
            cfg_stop2_q       <= '0;
            cfg_err           <= 1'b0;
        end else begin
            cfg_err <= cfg_bad;
            if (cfg_we && !cfg_bad) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (cfg_sel == 3'(i)) begin
                        cfg_length_q[i]      <= cfg_length;
                        cfg_parity_en_q[i]   <= cfg_parity_en;
                        cfg_parity_type_q[i] <= cfg_parity_type;
                        cfg_stop2_q[i]       <= cfg_stop2;
                    end
                end
            end
        end
    end

    always_ff @(posedge tx_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_valid) state_next = LAUNCH;
            LAUNCH:  state_next = WAIT;
            WAIT: begin
                if (tx_done) begin
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    state_next = ABORT;
                end
            end
            ABORT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame fields are snapshotted at grant so later config writes only affect the next frame.
    always_ff @(posedge tx_clk) begin
        if (rst) begin
            tx_data     <= 8'h00;
            length      <= 4'd8;
            parity_en   <= 1'b0;
            parity_type <= 1'b0;
            stop2       <= 1'b0;
            owner_id    <= 3'd0;
            ptr         <= 3'd0;
            timer       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        owner_id <= grant;
                        for (int i = 0; i < N_REQ; i++) begin
                            if (grant == 3'(i)) begin
                                tx_data     <= req_bus.req_data[8*i +: 8];
                                length      <= cfg_length_q[i];
                                parity_en   <= cfg_parity_en_q[i];
                                parity_type <= cfg_parity_type_q[i];
                                stop2       <= cfg_stop2_q[i];
                            end
                        end
                    end
                end
                LAUNCH: timer <= '0;
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (tx_done) begin
                        ptr <= next_ptr;
                    end
                end
                ABORT:   ptr <= next_ptr;
                default: ;
            endcase
        end
    end

    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ready_vec[i] = !rst && (state == IDLE) && any_valid && (grant == 3'(i));
        end
        tx_start   = !rst && (state == LAUNCH);
        done_valid = !rst && (state == WAIT) && tx_done;
        err_valid  = !rst && (state == ABORT);
        uart_rst   = rst || (state == ABORT);
        busy       = !rst && (state != IDLE);
    end

    assign req_bus.req_ready = ready_vec;
endmodule
